// File: rtl/decimal_key_entry_if.sv
// rtl/decimal_key_entry_if.sv - key entry bus: raw key lines and clear in, code/flags/BCD buffer out
interface decimal_key_entry_if #(
  parameter int NUM_KEYS = 10,
  parameter int DIGITS   = 4
);
  logic [NUM_KEYS-1:0] d;
  logic                clear;
  logic [3:0]          b;
  logic                valid;
  logic                error;
  logic [4*DIGITS-1:0] digits;
  logic [3:0]          count;

  modport master (output d, clear, input b, valid, error, digits, count);
  modport slave  (input d, clear, output b, valid, error, digits, count);
endinterface

// File: rtl/decimal_key_entry.sv
// rtl/decimal_key_entry.sv - synchronised, debounced key encoder with BCD digit entry buffer
// Accepts one key per press/release cycle; multi-key presses hold error until a clean release.
module decimal_key_entry #(
  parameter int NUM_KEYS        = 10,
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  decimal_key_entry_if.slave   bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = 4 * DIGITS;
  localparam logic [NUM_KEYS-1:0] IDLE_LEVEL = {NUM_KEYS{ACTIVE_LOW != 0}};
  localparam logic [NUM_KEYS-1:0] ONE_KEY    = NUM_KEYS'(1);
  localparam logic [CW-1:0]       CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]       CNT_MAX    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]       CNT_REL    = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_ACCEPT,
    S_HELD,
    S_ERROR
  } state_t;

  state_t              state, state_nxt;
  logic [NUM_KEYS-1:0] sync1, sync2, pressed;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [3:0]          key, key_nxt, key_idx;
  logic                is_none, is_single, accept;
  logic [3:0]          b_r, count_r;
  logic [DW-1:0]       digits_r, digits_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= bus.d;
      sync2 <= sync1;
    end
  end

  assign pressed   = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
  assign is_none   = (pressed == '0);
  assign is_single = !is_none && ((pressed & (pressed - ONE_KEY)) == '0);

  always_comb begin
    key_idx = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (pressed[k]) key_idx = 4'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      key   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      key   <= key_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    key_nxt   = key;
    case (state)
      S_IDLE: begin
        if (is_single) begin
          state_nxt = S_DEBOUNCE;
          key_nxt   = key_idx;
          cnt_nxt   = CNT_ONE;
        end else if (!is_none) begin
          state_nxt = S_ERROR;
          cnt_nxt   = '0;
        end
      end
      S_DEBOUNCE: begin
        if (is_single && key_idx == key) begin
          if (cnt == CNT_MAX) state_nxt = S_ACCEPT;
          else                cnt_nxt   = cnt + CNT_ONE;
        end else if (is_none || is_single) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_ERROR;
          cnt_nxt   = '0;
        end
      end
      S_ACCEPT: begin
        state_nxt = S_HELD;
        cnt_nxt   = '0;
      end
      // Both wait for DEBOUNCE_CYCLES consecutive released samples; any press restarts the wait.
      S_HELD, S_ERROR: begin
        if (is_none) begin
          if (cnt == CNT_REL) state_nxt = S_IDLE;
          else                cnt_nxt   = cnt + CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = (state == S_ACCEPT);

  generate
    if (DIGITS == 1) begin : g_one_digit
      assign digits_shift = key;
    end else begin : g_multi_digit
      assign digits_shift = {digits_r[DW-5:0], key};
    end
  endgenerate

  // Clear takes effect first, so a coincident digit accept leaves just that digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_r      <= '0;
      digits_r <= '0;
      count_r  <= '0;
    end else begin
      if (accept) b_r <= key;
      if (accept && key <= 4'd9) begin
        if (bus.clear) begin
          digits_r <= DW'(key);
          count_r  <= 4'd1;
        end else begin
          digits_r <= digits_shift;
          if (count_r != 4'(DIGITS)) count_r <= count_r + 4'd1;
        end
      end else if (bus.clear) begin
        digits_r <= '0;
        count_r  <= '0;
      end
    end
  end

  assign bus.b      = b_r;
  assign bus.valid  = accept;
  assign bus.error  = (state == S_ERROR);
  assign bus.digits = digits_r;
  assign bus.count  = count_r;
endmodule

// File: tb/tb_decimal_key_entry.sv
// tb/tb_decimal_key_entry.sv - directed and randomised key entry checked against a behavioural model
module tb_decimal_key_entry;
  localparam int NK = 12;
  localparam int ND = 4;
  localparam int DC = 4;
  localparam int AL = 1;

  localparam int M_READY  = 0;
  localparam int M_COUNT  = 1;
  localparam int M_ACCEPT = 2;
  localparam int M_LOCK   = 3;
  localparam int M_FAULT  = 4;

  logic clk;
  logic rst;

  decimal_key_entry_if #(.NUM_KEYS(NK), .DIGITS(ND)) bus ();

  decimal_key_entry #(
    .NUM_KEYS(NK),
    .DIGITS(ND),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int vcount   = 0;

  // Reference model: pressed-key sets seen through a two-sample delay, digits as a queue (newest last).
  int            mode;
  int            run;
  int            mkey;
  int            exp_b;
  int            digq[$];
  logic [NK-1:0] s1, s2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode  = M_READY;
    run   = 0;
    mkey  = 0;
    exp_b = 0;
    s1    = '0;
    s2    = '0;
    digq.delete();
  endtask

  task automatic model_step(input logic [NK-1:0] keys, input logic clr, input logic r);
    int n;
    int idx;
    if (r) begin
      model_reset();
      return;
    end
    n   = $countones(s2);
    idx = 0;
    for (int k = 0; k < NK; k++) if (s2[k]) idx = k;
    if (clr) digq.delete();
    case (mode)
      M_READY: begin
        if (n == 1) begin mode = M_COUNT; mkey = idx; run = 1; end
        else if (n > 1) begin mode = M_FAULT; run = 0; end
      end
      M_COUNT: begin
        if (n > 1) begin mode = M_FAULT; run = 0; end
        else if (n == 1 && idx == mkey) begin
          if (run == DC) mode = M_ACCEPT;
          else run++;
        end else mode = M_READY;
      end
      M_ACCEPT: begin
        exp_b = mkey;
        if (mkey <= 9) begin
          digq.push_back(mkey);
          if (digq.size() > ND) void'(digq.pop_front());
        end
        mode = M_LOCK;
        run  = 0;
      end
      default: begin
        if (n == 0) begin
          run++;
          if (run == DC) mode = M_READY;
        end else run = 0;
      end
    endcase
    s2 = s1;
    s1 = keys;
  endtask

  task automatic compare_outputs();
    logic [31:0] exp_digits;
    exp_digits = '0;
    for (int i = 0; i < digq.size(); i++)
      exp_digits |= 32'(digq[digq.size() - 1 - i]) << (4 * i);
    check("valid",  32'(bus.valid),  32'(mode == M_ACCEPT));
    check("error",  32'(bus.error),  32'(mode == M_FAULT));
    check("b",      32'(bus.b),      32'(exp_b));
    check("digits", 32'(bus.digits), exp_digits);
    check("count",  32'(bus.count),  32'(digq.size()));
    if (bus.valid === 1'b1) vcount++;
  endtask

  task automatic step(input logic [NK-1:0] keys, input logic clr, input logic r);
    @(negedge clk);
    compare_outputs();
    bus.d     = (AL != 0) ? ~keys : keys;
    bus.clear = clr;
    rst       = r;
    model_step(keys, clr, r);
  endtask

  task automatic hold(input logic [NK-1:0] keys, input int len);
    for (int i = 0; i < len; i++) step(keys, 1'b0, 1'b0);
  endtask

  initial begin
    logic [NK-1:0] keys;
    int            kind;
    int            len;
    int            a;
    int            c;
    int            v0;

    rst       = 1'b1;
    bus.d     = '1;
    bus.clear = 1'b0;
    model_reset();

    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    check("reset_count", 32'(bus.count), 32'd0);
    hold('0, 3);

    hold(NK'(1) << 3, 12);
    hold('0, 8);
    check("key3_b", 32'(bus.b), 32'd3);
    check("key3_digits", 32'(bus.digits), 32'h0003);
    check("key3_count", 32'(bus.count), 32'd1);

    v0 = vcount;
    hold(NK'(1) << 5, 3);
    hold('0, 4);
    hold(NK'(1) << 5, 10);
    hold('0, 8);
    check("glitch_pulses", 32'(vcount - v0), 32'd1);
    check("glitch_b", 32'(bus.b), 32'd5);

    v0 = vcount;
    hold(NK'(1) << 5, 4);
    hold(NK'(1) << 6, 3);
    hold('0, 8);
    check("swap_no_valid", 32'(vcount - v0), 32'd0);

    step('0, 1'b1, 1'b0);
    v0 = vcount;
    for (int k = 1; k <= 5; k++) begin
      hold(NK'(1) << k, 8);
      hold('0, 7);
    end
    check("seq_digits", 32'(bus.digits), 32'h2345);
    check("seq_count", 32'(bus.count), 32'd4);
    check("seq_pulses", 32'(vcount - v0), 32'd5);

    hold((NK'(1) << 2) | (NK'(1) << 7), 6);
    check("multi_error", 32'(bus.error), 32'd1);
    hold('0, 8);
    check("multi_cleared", 32'(bus.error), 32'd0);

    hold(NK'(1) << 11, 8);
    hold('0, 7);
    check("cmd_b", 32'(bus.b), 32'd11);
    check("cmd_digits", 32'(bus.digits), 32'h2345);

    hold(NK'(1) << 8, 7);
    step(NK'(1) << 8, 1'b1, 1'b0);
    hold('0, 7);
    check("clr_acc_digits", 32'(bus.digits), 32'h0008);
    check("clr_acc_count", 32'(bus.count), 32'd1);

    hold(NK'(1) << 4, 4);
    step(NK'(1) << 4, 1'b0, 1'b1);
    step(NK'(1) << 4, 1'b0, 1'b0);
    check("rst_deb_b", 32'(bus.b), 32'd0);
    hold(NK'(1) << 4, 10);
    hold('0, 7);
    check("redebounce_b", 32'(bus.b), 32'd4);
    hold((NK'(1) << 1) | (NK'(1) << 9), 5);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    check("rst_err_error", 32'(bus.error), 32'd0);
    hold('0, 3);

    for (int seg = 0; seg < 450; seg++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        keys = NK'(1) << $urandom_range(0, NK - 1);
        len  = $urandom_range(1, 12);
      end else if (kind < 8) begin
        keys = '0;
        len  = $urandom_range(1, 8);
      end else begin
        a    = $urandom_range(0, NK - 1);
        c    = (a + $urandom_range(1, NK - 1)) % NK;
        keys = (NK'(1) << a) | (NK'(1) << c);
        len  = $urandom_range(2, 8);
      end
      for (int i = 0; i < len; i++)
        step(keys, $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
    end
    hold('0, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
